// File: rtl/ex2_sad_pkg.sv
// ex2_sad_pkg: shared types and helpers for the EX2 SAD tracker.
//   - sad_state_e : tracker FSM states
//   - DEF_*       : default pixel / lane / width parameters
//   - SAD_MAX     : all-ones SAD value (the "no best yet" marker)
//   - absdiff()   : unsigned |a-b| for one pixel
package ex2_sad_pkg;

  localparam int DEF_PIX_W   = 8;
  localparam int DEF_LANES   = 4;
  localparam int DEF_BEATS_W = 8;
  localparam int DEF_SAD_W   = 32;

  localparam logic [DEF_SAD_W-1:0] SAD_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_COMPARE = 2'd3
  } sad_state_e;

  function automatic logic [DEF_PIX_W-1:0] absdiff(input logic [DEF_PIX_W-1:0] a,
                                                   input logic [DEF_PIX_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sad_lane_absdiff.sv
// sad_lane_absdiff: combinational sum of per-lane absolute pixel differences.
// Ports:
//   a, b : packed pixel words (LANES pixels of PIX_W bits each)
//   sum  : sum over lanes of |a_i - b_i|, wide enough never to overflow
module sad_lane_absdiff
  import ex2_sad_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int LANES = DEF_LANES,
  parameter int SUM_W = PIX_W + $clog2(LANES)
) (
  input  logic [PIX_W*LANES-1:0] a,
  input  logic [PIX_W*LANES-1:0] b,
  output logic [SUM_W-1:0]       sum
);

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + SUM_W'(absdiff(a[i*PIX_W +: PIX_W], b[i*PIX_W +: PIX_W]));
    end
  end

endmodule

// File: rtl/ex2_sad_tracker.sv
// ex2_sad_tracker: EX2-stage SAD accumulator and best-candidate tracker.
// Accumulates the sum of absolute differences over NumBeats beats for one
// candidate, then compares it against the running best and keeps the best
// SAD with its x/y coordinates.
//
// Handshake: a beat is accepted when Start is high in IDLE (Start carries
// the first beat) or when BeatValid is high in ACCUM without Start. There
// is no backpressure; beats offered in any other state are dropped, and a
// Start outside IDLE also raises ProtoErr for that cycle.
//
// Ports:
//   Clk, Reset        : clock, synchronous active-high reset
//   Clear             : reinitialise best SAD / coordinates
//   Start, BeatValid  : first beat of a candidate / further beats
//   NumBeats          : beats per candidate (0 means 1), sampled on Start
//   FrameWord, WindowWord : packed pixels for this beat
//   CandX, CandY      : candidate coordinates, sampled on Start
//   Busy, Done, Updated, ProtoErr : status / pulses
//   CandSad, BestSad, BestX, BestY : results
//   DbgState          : current FSM state
//
// Build option: define SAD_EARLY_TERM_EN to abort a candidate as soon as
// its partial SAD can no longer beat the current best.
module ex2_sad_tracker
  import ex2_sad_pkg::*;
#(
  parameter int PIX_W   = DEF_PIX_W,
  parameter int LANES   = DEF_LANES,
  parameter int BEATS_W = DEF_BEATS_W,
  parameter int SAD_W   = DEF_SAD_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Clear,
  input  logic               Start,
  input  logic               BeatValid,
  input  logic [BEATS_W-1:0] NumBeats,
  input  logic [31:0]        FrameWord,
  input  logic [31:0]        WindowWord,
  input  logic [31:0]        CandX,
  input  logic [31:0]        CandY,
  output logic               Busy,
  output logic               Done,
  output logic               Updated,
  output logic               ProtoErr,
  output logic [SAD_W-1:0]   CandSad,
  output logic [SAD_W-1:0]   BestSad,
  output logic [31:0]        BestX,
  output logic [31:0]        BestY,
  output sad_state_e         DbgState
);

  localparam int SUM_W = PIX_W + $clog2(LANES);

  sad_state_e         state_q, state_d;
  logic [BEATS_W-1:0] num_q, cnt_q, cnt_next, num_eff;
  logic [31:0]        cand_x_q, cand_y_q;
  logic               a_vld_q, b_vld_q;
  logic [SUM_W-1:0]   lane_sum, a_sum_q, b_sum_q;
  logic [SAD_W-1:0]   acc_q, acc_add;
  logic [SAD_W:0]     acc_wide;
  logic [SAD_W-1:0]   cand_sad_q, best_sad_q;
  logic [31:0]        best_x_q, best_y_q;
  logic               start_ok, beat_ok, improve, early_abort;

  sad_lane_absdiff #(.PIX_W(PIX_W), .LANES(LANES), .SUM_W(SUM_W)) u_lanes (
    .a   (FrameWord),
    .b   (WindowWord),
    .sum (lane_sum)
  );

  assign start_ok = Start && (state_q == ST_IDLE);
  // A Start outside IDLE is rejected outright, even with BeatValid set.
  assign beat_ok  = start_ok || ((state_q == ST_ACCUM) && BeatValid && !Start);
  assign cnt_next = cnt_q + BEATS_W'(1);
  assign num_eff  = (NumBeats == '0) ? BEATS_W'(1) : NumBeats;

  // Saturating accumulate of the Stage-B operand.
  assign acc_wide = {1'b0, acc_q} + {{(SAD_W + 1 - SUM_W){1'b0}}, b_sum_q};
  assign acc_add  = acc_wide[SAD_W] ? '1 : acc_wide[SAD_W-1:0];
  assign improve  = acc_q < best_sad_q;

`ifdef SAD_EARLY_TERM_EN
  assign early_abort = ((state_q == ST_ACCUM) || (state_q == ST_DRAIN)) &&
                       b_vld_q && (acc_add >= best_sad_q);
`else
  assign early_abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    Done    = 1'b0;
    Updated = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (Start) state_d = (num_eff == BEATS_W'(1)) ? ST_DRAIN : ST_ACCUM;
      end
      ST_ACCUM: begin
        if (beat_ok && (cnt_next == num_q)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Stage B drains into acc on this edge once Stage A is empty.
        if (!a_vld_q) state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        Done    = 1'b1;
        Updated = improve && !Clear;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (early_abort) state_d = ST_COMPARE;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      num_q      <= '0;
      cnt_q      <= '0;
      cand_x_q   <= '0;
      cand_y_q   <= '0;
      a_vld_q    <= 1'b0;
      a_sum_q    <= '0;
      b_vld_q    <= 1'b0;
      b_sum_q    <= '0;
      acc_q      <= '0;
      cand_sad_q <= '0;
      best_sad_q <= '1;
      best_x_q   <= '0;
      best_y_q   <= '0;
    end else begin
      state_q <= state_d;

      // Pipe: Stage A holds the lane sum, Stage B feeds the accumulator.
      // An early abort discards every beat still in flight.
      a_vld_q <= beat_ok && !early_abort;
      if (beat_ok) a_sum_q <= lane_sum;
      b_vld_q <= a_vld_q && !early_abort;
      b_sum_q <= a_sum_q;

      if (state_q == ST_COMPARE) acc_q <= '0;
      else if (b_vld_q)          acc_q <= acc_add;

      if (start_ok) begin
        num_q    <= num_eff;
        cnt_q    <= BEATS_W'(1);
        cand_x_q <= CandX;
        cand_y_q <= CandY;
      end else if (beat_ok) begin
        cnt_q <= cnt_next;
      end

      if (state_q == ST_COMPARE) cand_sad_q <= acc_q;

      if (Clear) begin
        best_sad_q <= '1;
        best_x_q   <= '0;
        best_y_q   <= '0;
      end else if (Updated) begin
        best_sad_q <= acc_q;
        best_x_q   <= cand_x_q;
        best_y_q   <= cand_y_q;
      end
    end
  end

  assign Busy     = (state_q != ST_IDLE);
  assign ProtoErr = Start && (state_q != ST_IDLE);
  assign CandSad  = cand_sad_q;
  assign BestSad  = best_sad_q;
  assign BestX    = best_x_q;
  assign BestY    = best_y_q;
  assign DbgState = state_q;

endmodule
